// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the 5-stage pipeline datapath and the hazard sequencer.
//
// Pipeline -> sequencer (driven by the master side):
//   id_rs1, id_rs2    [4:0] source register fields of the IF/ID instruction
//   id_uses_rs2             ID instruction reads rs2
//   ex_mem_read             ID/EX holds a load
//   ex_rd             [4:0] ID/EX destination register
//   mem_req                 EX/MEM accesses data memory
//   mem_ready               data memory completes this cycle
//   mem_branch_taken        taken branch/jump resolved in EX/MEM
//   wb_sys                  MEM/WB holds ecall/ebreak
//   resume                  leave HALT
// Sequencer -> pipeline (driven by the slave side):
//   pc_load, stall, freeze, flush_if_id, flush_id_ex, flush_ex_mem
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs2;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       mem_req;
    logic       mem_ready;
    logic       mem_branch_taken;
    logic       wb_sys;
    logic       resume;

    logic       pc_load;
    logic       stall;
    logic       freeze;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       flush_ex_mem;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
               mem_req, mem_ready, mem_branch_taken, wb_sys, resume,
        input  pc_load, stall, freeze, flush_if_id, flush_id_ex, flush_ex_mem
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
               mem_req, mem_ready, mem_branch_taken, wb_sys, resume,
        output pc_load, stall, freeze, flush_if_id, flush_id_ex, flush_ex_mem
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Central sequencer for the 5-stage RISC-V pipeline: load-use stalls,
// memory-wait freezes, branch flushes, boot hold, halt on ecall/ebreak
// and a sticky memory-timeout error state.
//
// Parameters:
//   BOOT_CYCLES  cycles the pipe is held and flushed after reset (1..15)
//   MEM_TIMEOUT  consecutive WAIT cycles tolerated before ERR (1..65535)
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   pipe             hazard_ctrl_if.slave (hazard inputs, pipeline controls)
//   halted           core sits in HALT
//   mem_err          sticky memory-timeout flag
//   state [2:0]      FSM state: BOOT=0 RUN=1 WAIT=2 HALT=3 ERR=4
//   stall_cnt, flush_cnt, wait_cnt [31:0]  performance counters
//
// Optional feature macro HAZARD_PERF_CNT_EN: when defined, the three
// counters are built (saturating, cleared by rst); otherwise they read 0.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave pipe,
    output logic         halted,
    output logic         mem_err,
    output logic [2:0]   state,
    output logic [31:0]  stall_cnt,
    output logic [31:0]  flush_cnt,
    output logic [31:0]  wait_cnt
);

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_RUN  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HALT = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [3:0]  BOOT_LAST    = 4'(BOOT_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT);

    state_t      cur_state;
    logic [3:0]  boot_cnt;
    logic [15:0] timeout_cnt;
    logic        mem_err_q;
    logic        mem_wait;
    logic        load_use;

    assign mem_wait = pipe.mem_req & ~pipe.mem_ready;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = pipe.ex_mem_read & (pipe.ex_rd != 5'd0) &
                      ((pipe.ex_rd == pipe.id_rs1) |
                       (pipe.id_uses_rs2 & (pipe.ex_rd == pipe.id_rs2)));

    assign state   = cur_state;
    assign halted  = (cur_state == ST_HALT);
    assign mem_err = mem_err_q;

    // Pipeline controls. Freeze always wins over stall, so a hazard or
    // branch arriving while memory is busy is simply held until later.
    always_comb begin
        pipe.pc_load      = 1'b0;
        pipe.stall        = 1'b0;
        pipe.freeze       = 1'b0;
        pipe.flush_if_id  = 1'b0;
        pipe.flush_id_ex  = 1'b0;
        pipe.flush_ex_mem = 1'b0;
        unique case (cur_state)
            ST_BOOT: begin
                pipe.freeze       = 1'b1;
                pipe.flush_if_id  = 1'b1;
                pipe.flush_id_ex  = 1'b1;
                pipe.flush_ex_mem = 1'b1;
            end
            ST_RUN: begin
                if (mem_wait) begin
                    pipe.freeze = 1'b1;
                end else if (pipe.mem_branch_taken) begin
                    pipe.pc_load      = 1'b1;
                    pipe.flush_if_id  = 1'b1;
                    pipe.flush_id_ex  = 1'b1;
                    pipe.flush_ex_mem = 1'b1;
                end else if (load_use) begin
                    pipe.stall = 1'b1;
                end else begin
                    pipe.pc_load = 1'b1;
                end
            end
            ST_WAIT: begin
                if (pipe.mem_ready) begin
                    pipe.pc_load = 1'b1;
                end else begin
                    pipe.freeze = 1'b1;
                end
            end
            ST_HALT: begin
                // Resume restarts fetch from a clean pipe.
                if (pipe.resume) begin
                    pipe.pc_load      = 1'b1;
                    pipe.flush_if_id  = 1'b1;
                    pipe.flush_id_ex  = 1'b1;
                    pipe.flush_ex_mem = 1'b1;
                end else begin
                    pipe.freeze = 1'b1;
                end
            end
            default: begin
                pipe.freeze = 1'b1;
            end
        endcase
    end

    // Sequencer state. A memory wait beats wb_sys; the system instruction
    // stays frozen in MEM/WB and is seen again once RUN resumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state   <= ST_BOOT;
            boot_cnt    <= 4'd0;
            timeout_cnt <= 16'd0;
            mem_err_q   <= 1'b0;
        end else begin
            unique case (cur_state)
                ST_BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        cur_state <= ST_RUN;
                    end else begin
                        boot_cnt <= boot_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (mem_wait) begin
                        cur_state   <= ST_WAIT;
                        timeout_cnt <= 16'd1;
                    end else if (pipe.wb_sys) begin
                        cur_state <= ST_HALT;
                    end
                end
                ST_WAIT: begin
                    if (pipe.mem_ready) begin
                        cur_state   <= ST_RUN;
                        timeout_cnt <= 16'd0;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        cur_state <= ST_ERR;
                        mem_err_q <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end
                ST_HALT: begin
                    if (pipe.resume) begin
                        cur_state <= ST_RUN;
                    end
                end
                ST_ERR: begin
                    cur_state <= ST_ERR;
                end
                default: begin
                    cur_state <= ST_BOOT;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic branch_flush;

    // Only redirects from a resolved branch count as flushes; boot and
    // resume flushes are housekeeping.
    assign branch_flush = (cur_state == ST_RUN) & ~mem_wait & pipe.mem_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
            wait_cnt  <= 32'd0;
        end else begin
            if (pipe.stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (branch_flush && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if ((cur_state == ST_WAIT) && (wait_cnt != 32'hFFFF_FFFF)) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
        end
    end
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
    assign wait_cnt  = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RISC-V core. It drives the stall, freeze and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.
- Detects load-use hazards and stalls for them.
- Freezes the whole pipe while data memory is not ready.
- Flushes younger stages on a taken branch or jump resolved in MEM.
- Holds the pipe after reset, and halts on a system instruction reaching WB.

Parameters:
BOOT_CYCLES, 4, cycles the pipe is held and flushed after reset (range 1..15).
MEM_TIMEOUT, 255, max consecutive memory-wait cycles before entering ERR (range 1..65535).

Ports:
clk  input  1  system clock
rst  input  1  reset
id_rs1  input  5  rs1 field of IF_ID instruction
id_rs2  input  5  rs2 field of IF_ID instruction
id_uses_rs2  input  1  ID instruction reads rs2
ex_mem_read  input  1  ID_EX stage holds a load
ex_rd  input  5  ID_EX destination register
mem_req  input  1  EX_MEM stage accesses memory (read or write)
mem_ready  input  1  data memory completes access this cycle
mem_branch_taken  input  1  taken branch/jump resolved in EX_MEM
wb_sys  input  1  MEM_WB holds ecall/ebreak
resume  input  1  leave HALT
pc_load  output  1  PC register write enable
stall  output  1  hold IF/ID, insert bubble into ID/EX
freeze  output  1  hold all four pipeline registers and PC
flush_if_id  output  1  clear IF/ID next edge
flush_id_ex  output  1  clear ID/EX control bits next edge
flush_ex_mem  output  1  clear EX_MEM control bits next edge
halted  output  1  core in HALT
mem_err  output  1  sticky memory-timeout flag
state  output  3  FSM state
stall_cnt, flush_cnt, wait_cnt  output  32 each  performance counters

Behaviour:
Interface:
- One clock, clk.
- rst is synchronous and active-high; it is sampled only on the rising edge of clk.

FSM states, registered: BOOT=0, RUN=1, WAIT=2, HALT=3, ERR=4.
- Reset gives state=BOOT, boot counter=0, timeout counter=0, mem_err=0, all counters=0.

Outputs are combinational from the state and current inputs.

BOOT:
- freeze=1, all flushes=1, pc_load=0, stall=0.
- Moves to RUN when the boot counter reaches BOOT_CYCLES-1, so BOOT lasts exactly BOOT_CYCLES cycles.

RUN, evaluated in priority order:
1. mem_req & ~mem_ready: freeze=1, pc_load=0, no flush. Next state WAIT, timeout counter=1. Any branch or hazard present in this cycle is ignored.
2. mem_branch_taken: flush_if_id, flush_id_ex and flush_ex_mem = 1 for exactly one cycle; pc_load=1 (redirect); stall=0. A simultaneous load-use hazard is suppressed.
3. Load-use hazard: ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)). Response: stall=1, pc_load=0, for one cycle only; the hazard clears once the bubble reaches ID/EX.
4. Otherwise: pc_load=1 and all other controls 0.

wb_sys in RUN:
- The cycle's outputs are computed per the RUN priority list above.
- Next state is HALT, unless rule 1 also applies; then WAIT wins and wb_sys is re-evaluated after return to RUN.

WAIT:
- freeze=1, pc_load=0.
- On mem_ready: outputs take the RUN normal values that cycle, next state RUN, timeout counter cleared.
- If the timeout counter reaches MEM_TIMEOUT without mem_ready: next state ERR, mem_err set.

HALT:
- freeze=1, pc_load=0, halted=1.
- resume=1: one cycle with all three flushes=1 and pc_load=1, then next state RUN.

ERR:
- freeze=1, pc_load=0, mem_err=1.
- Exits only via rst.

General rules:
- rst mid-operation overrides every state, including ERR.
- x0 (register 0) never triggers a hazard.
- stall and freeze are never both 1: freeze has priority.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cnt increments on each cycle with stall=1; flush_cnt on each branch-flush cycle; wait_cnt on each WAIT cycle. All are 32-bit, saturating at 0xFFFFFFFF, and cleared by rst.
- Undefined: the three counter ports are tied to 0 and no counter registers are built.

Test Plan:
- Reset, BOOT_CYCLES=4: freeze=1 and flushes=1 for cycles 0-3; state=RUN and pc_load=1 at cycle 4.
- ex_mem_read=1, ex_rd=5, id_rs1=5: stall=1 and pc_load=0 for one cycle. Repeat with ex_rd=0: stall=0.
- mem_branch_taken=1 together with a load-use hazard on rd=7: all three flushes=1, pc_load=1, stall=0 for one cycle.
- mem_req=1, mem_ready low for 3 cycles then high: freeze=1 for 3 cycles, RUN restored, wait_cnt=3 (feature on).
- MEM_TIMEOUT=8, mem_ready stuck low: state=ERR after 8 WAIT cycles, mem_err=1. rst then returns state to BOOT and clears mem_err.
- wb_sys=1: state=HALT, halted=1. resume=1: one flush cycle, then RUN.
